// File: rtl/sha_pkg.sv
// SHA-256 shared definitions: opcodes, FSM states, IV, round constants
// and the sigma functions used by the round logic and message schedule.
package sha_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_NEW  = 2'b01,
        OP_CONT = 2'b10,
        OP_READ = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_OUT,
        ST_ACK,
        ST_WAIT_NOP
    } state_e;

    // Eight 32-bit words; index 0 is H0 / working variable a.
    typedef logic [7:0][31:0] hvec_t;

    localparam hvec_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Ports: st_i = a..h (index 0 = a), kt_i/wt_i round inputs, st_o = next a..h.
module sha256_round
    import sha_pkg::*;
(
    input  hvec_t       st_i,
    input  logic [31:0] kt_i,
    input  logic [31:0] wt_i,
    output hvec_t       st_o
);

    logic [31:0] ch;
    logic [31:0] maj;
    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        ch  = (st_i[4] & st_i[5]) ^ (~st_i[4] & st_i[6]);
        maj = (st_i[0] & st_i[1]) ^ (st_i[0] & st_i[2]) ^ (st_i[1] & st_i[2]);
        t1  = st_i[7] + big_sigma1(st_i[4]) + ch + kt_i + wt_i;
        t2  = big_sigma0(st_i[0]) + maj;
        // h<=g, g<=f, f<=e, e<=d+t1, d<=c, c<=b, b<=a, a<=t1+t2
        st_o = {st_i[6:4], st_i[3] + t1, st_i[2:0], t1 + t2};
    end

endmodule

// File: rtl/sha.sv
// SHA-256 engine over host-padded 512-bit blocks, byte-serial in and out.
// Ports: opcode command, data_in/valid_in/ready_in load, data_out/data_valid/data_ready digest, ack_valid/ack_ready completion.
module sha
    import sha_pkg::*;
#(
    parameter logic [1:0] MODULE_ID = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        ack_valid,
    input  logic        ack_ready,
    output logic [1:0]  module_source_id,
    input  logic [1:0]  opcode,
    input  logic [1:0]  source_id,
    input  logic [1:0]  dest_id,
    input  logic        encdec,
    input  logic [23:0] addr
);

    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    hvec_t             h_q, h_d;
    hvec_t             v_q, v_d;
    logic [15:0][31:0] w_q, w_d;
    hvec_t             round_st;
    logic [31:0]       w_next;
    logic [31:0]       out_word;
    logic              unused_ok;

    assign module_source_id = MODULE_ID;
    assign unused_ok = ^{source_id, dest_id, encdec, addr};

    sha256_round u_round (
        .st_i (v_q),
        .kt_i (K[cnt_q]),
        .wt_i (w_q[0]),
        .st_o (round_st)
    );

    // w_q is a sliding window W[t..t+15]; this is W[t+16].
    assign w_next = small_sigma1(w_q[14]) + w_q[9]
                  + small_sigma0(w_q[1]) + w_q[0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_d        = h_q;
        v_d        = v_q;
        w_d        = w_q;
        ready_in   = 1'b0;
        data_valid = 1'b0;
        ack_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (opcode != OP_NOP) begin
                    cnt_d = 6'd0;
                    if (opcode == OP_READ) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_LOAD;
                        if (opcode == OP_NEW) h_d = IV;
                    end
                end
            end
            ST_LOAD: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    // Big-endian: each word fills from its MSB byte.
                    w_d[cnt_q[5:2]] = {w_q[cnt_q[5:2]][23:0], data_in};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        state_d = ST_ROUND;
                        v_d     = h_q;
                    end
                end
            end
            ST_ROUND: begin
                v_d   = round_st;
                w_d   = {w_next, w_q[15:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
                state_d = ST_ACK;
            end
            ST_OUT: begin
                data_valid = 1'b1;
                if (data_ready) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = ST_ACK;
                        cnt_d   = 6'd0;
                    end
                end
            end
            ST_ACK: begin
                ack_valid = 1'b1;
                if (ack_ready) state_d = ST_WAIT_NOP;
            end
            ST_WAIT_NOP: begin
                if (opcode == OP_NOP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_word = h_q[cnt_q[4:2]];
        data_out = 8'h00;
        if (state_q == ST_OUT) begin
            unique case (cnt_q[1:0])
                2'd0: data_out = out_word[31:24];
                2'd1: data_out = out_word[23:16];
                2'd2: data_out = out_word[15:8];
                2'd3: data_out = out_word[7:0];
                default: data_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            h_q     <= IV;
            v_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            v_q     <= v_d;
            w_q     <= w_d;
        end
    end

endmodule

// File: tb/tb_sha.sv
// Self-checking bench for sha: known FIPS vectors plus random blocks
// compared with a plain-arithmetic SHA-256 model held in the bench.
module tb_sha;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        ack_valid;
    logic        ack_ready = 1'b0;
    logic [1:0]  module_source_id;
    logic [1:0]  opcode = 2'b00;
    logic [1:0]  source_id = 2'b01;
    logic [1:0]  dest_id = 2'b11;
    logic        encdec = 1'b1;
    logic [23:0] addr = 24'h5a5a5a;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in          (data_in),
        .valid_in         (valid_in),
        .ready_in         (ready_in),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .ack_valid        (ack_valid),
        .ack_ready        (ack_ready),
        .module_source_id (module_source_id),
        .opcode           (opcode),
        .source_id        (source_id),
        .dest_id          (dest_id),
        .encdec           (encdec),
        .addr             (addr)
    );

    localparam logic [255:0] TIV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-block compression: full 64-entry schedule, then 64 rounds.
    function automatic logic [255:0] compress(input logic [255:0] hin,
                                              input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] hv [8];
        logic [31:0] s0, s1, t1, t2, ch, mj;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32 * i -: 32];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        v = hv;
        for (int t = 0; t < 64; t++) begin
            s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
            ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1 = v[7] + s1 + ch + TK[t] + w[t];
            s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2 = s0 + mj;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
            v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [255:0] got,
                           input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Handshake exclusivity and constant bus ID, every cycle.
    always @(negedge clk) begin
        checks++;
        if (({ready_in, data_valid, ack_valid} inside
             {3'b011, 3'b101, 3'b110, 3'b111}) ||
            module_source_id !== 2'b10) begin
            failures++;
            $display("FAIL monitor rdy=%b dv=%b ack=%b id=%b expected one-hot id=10",
                     ready_in, data_valid, ack_valid, module_source_id);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached expected finish earlier");
        $fatal(1, "timeout");
    end

    task automatic wait_ack(input int dly);
        int bad;
        bad = 0;
        for (int d = 0; d < dly; d++) begin
            if (!ack_valid) bad++;
            @(negedge clk);
        end
        chk_int("ack_hold", bad, 0);
        chk_int("ack_valid", int'(ack_valid), 1);
        ack_ready = 1'b1;
        @(negedge clk);
        ack_ready = 1'b0;
        chk_int("ack_drop", int'(ack_valid), 0);
    endtask

    task automatic feed(input logic [1:0] op, input logic [511:0] blk,
                        input bit hold);
        int k, guard;
        bit acc;
        @(negedge clk);
        opcode = op;
        @(negedge clk);
        if (!hold) opcode = 2'b00;
        k = 0;
        guard = 0;
        while (k < 64 && guard < 1000) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in = blk[511 - 8 * k -: 8];
            acc = valid_in && ready_in;
            @(negedge clk);
            if (acc) k++;
            guard++;
        end
        valid_in = 1'b0;
        chk_int("load_bytes", k, 64);
        chk_int("ready_drop", int'(ready_in), 0);
    endtask

    task automatic do_hash(input logic [1:0] op, input logic [511:0] blk,
                           input bit hold, input int ackdly);
        int n, bad;
        feed(op, blk, hold);
        n = 1;
        while (!ack_valid && n < 200) begin
            valid_in = 1'($urandom_range(0, 1));
            data_ready = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            @(negedge clk);
            n++;
        end
        valid_in = 1'b0;
        data_ready = 1'b0;
        chk_int("latency", n, 66);
        wait_ack(ackdly);
        if (hold) begin
            bad = 0;
            repeat (8) begin
                @(negedge clk);
                if (ready_in || data_valid || ack_valid) bad++;
            end
            chk_int("no_retrigger", bad, 0);
            opcode = 2'b00;
        end
        @(negedge clk);
    endtask

    task automatic do_read(input logic [255:0] exp, input bit stall,
                           input int ackdly);
        logic [255:0] got;
        logic [7:0]   last;
        int k, guard, bad;
        bit held;
        @(negedge clk);
        opcode = 2'b11;
        @(negedge clk);
        opcode = 2'b00;
        got = '0;
        last = 8'h00;
        k = 0;
        guard = 0;
        bad = 0;
        held = 1'b0;
        while (k < 32 && guard < 2000) begin
            if (!data_valid) bad++;
            if (held && data_out !== last) bad++;
            data_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (data_ready) begin
                got = {got[247:0], data_out};
                k++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                last = data_out;
            end
            @(negedge clk);
            guard++;
        end
        data_ready = 1'b0;
        chk_int("read_bytes", k, 32);
        chk_int("read_stable", bad, 0);
        chk_vec("digest", got, exp);
        wait_ack(ackdly);
        @(negedge clk);
    endtask

    typedef struct {
        logic [511:0] b0;
        logic [511:0] b1;
        bit           two;
        logic [255:0] dig;
    } vec_t;

    vec_t vecs [6];
    logic [511:0] abc_blk;

    initial begin
        int bad;
        abc_blk = {32'h61626380, 416'h0, 64'h18};
        vecs[0] = '{abc_blk, 512'h0, 1'b0,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
        vecs[1] = '{{8'h80, 504'h0}, 512'h0, 1'b0,
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        vecs[2] = '{{448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                     8'h80, 56'h0},
            {448'h0, 64'h1c0}, 1'b1,
            256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
        for (int i = 3; i < 6; i++) begin
            for (int j = 0; j < 16; j++) begin
                vecs[i].b0[511 - 32 * j -: 32] = $urandom;
                vecs[i].b1[511 - 32 * j -: 32] = $urandom;
            end
            vecs[i].two = (i != 4);
            vecs[i].dig = compress(TIV, vecs[i].b0);
            if (vecs[i].two) vecs[i].dig = compress(vecs[i].dig, vecs[i].b1);
        end

        repeat (3) @(negedge clk);
        chk_int("rst_outputs",
                int'({ready_in, data_valid, ack_valid, data_out}), 0);
        chk_int("rst_id", int'(module_source_id), 2);
        rst_n = 1'b1;
        @(negedge clk);

        do_read(TIV, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            do_hash(2'b01, vecs[i].b0, 1'b0, $urandom_range(0, 3));
            if (vecs[i].two) do_hash(2'b10, vecs[i].b1, 1'b0, 0);
            do_read(vecs[i].dig, (i % 2) == 1, 0);
        end

        do_read(vecs[5].dig, 1'b1, 5);

        feed(2'b01, abc_blk, 1'b0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_int("rst_mid_round",
                int'({ready_in, data_valid, ack_valid, data_out}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (ack_valid) bad++;
        end
        chk_int("no_ack_after_rst", bad, 0);
        do_read(TIV, 1'b0, 0);
        do_hash(2'b01, abc_blk, 1'b0, 1);
        do_read(vecs[0].dig, 1'b1, 2);

        @(negedge clk);
        opcode = 2'b11;
        @(negedge clk);
        opcode = 2'b00;
        data_ready = 1'b1;
        repeat (5) @(negedge clk);
        data_ready = 1'b0;
        chk_int("out_before_rst", int'(data_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_int("rst_mid_out",
                int'({ready_in, data_valid, ack_valid, data_out}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_valid || data_valid) bad++;
        end
        chk_int("no_ack_after_out_rst", bad, 0);
        do_read(TIV, 1'b0, 0);

        do_hash(2'b01, abc_blk, 1'b1, 3);
        do_read(vecs[0].dig, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha.md
SHA -- requirements
Module: sha

Interface
REQ-001 SHALL have parameter MODULE_ID, default 2'b10, this block's bus ID driven on module_source_id.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port data_in, input, 8 bits, message byte.
REQ-005 SHALL have ports valid_in (input, 1 bit) and ready_in (output, 1 bit), the data_in handshake.
REQ-006 SHALL have port data_out, output, 8 bits, digest byte.
REQ-007 SHALL have ports data_valid (output, 1 bit) and data_ready (input, 1 bit), the data_out handshake.
REQ-008 SHALL have ports ack_valid (output, 1 bit) and ack_ready (input, 1 bit), the completion handshake.
REQ-009 SHALL have port module_source_id, output, 2 bits, constant MODULE_ID.
REQ-010 SHALL have ports opcode, source_id and dest_id, inputs, 2 bits each, the transaction command.
REQ-011 SHALL have ports encdec (input, 1 bit) and addr (input, 24 bits); both are ignored.

Function
REQ-012 SHALL implement SHA-256 (FIPS 180-4) over pre-padded 512-bit blocks; the host does all padding.
REQ-013 Opcodes SHALL be: 00 NOP, 01 HASH_NEW (load IV into H0..H7, then absorb one block), 10 HASH_CONT (absorb one block into the current H), 11 READ (stream the digest).
REQ-014 States SHALL be IDLE, LOAD, ROUND, FINAL, OUT, ACK, WAIT_NOP.
REQ-015 In IDLE, a nonzero opcode SHALL be captured on a clock edge; 01/10 go to LOAD and 11 goes to OUT.
REQ-016 LOAD SHALL assert ready_in and accept one byte per cycle with valid_in&&ready_in, exactly 64 bytes, big-endian; byte 0 is W0[31:24].
REQ-017 After the 64th byte, ready_in SHALL drop the next cycle.
REQ-018 ROUND SHALL do one compression round per cycle for 64 cycles, using a 16-word rolling schedule and a K constant ROM.
REQ-019 FINAL SHALL take 1 cycle: Hi += working variable, modulo 2^32.
REQ-020 OUT SHALL present 32 bytes, H0[31:24] first, H7[7:0] last, with data_valid held high.
REQ-021 In OUT, data_out SHALL advance only on data_valid&&data_ready and SHALL stay stable while stalled.
REQ-022 ACK SHALL hold ack_valid high until ack_ready, then go to WAIT_NOP; FINAL and the last OUT byte both lead to ACK.
REQ-023 WAIT_NOP SHALL return to IDLE when opcode==00, so a held opcode does not retrigger.
REQ-024 Opcode changes outside IDLE/WAIT_NOP SHALL be ignored.
REQ-025 ready_in, data_valid and ack_valid SHALL never be high simultaneously.
REQ-026 valid_in outside LOAD and data_ready outside OUT SHALL be ignored.
REQ-027 READ before any hash SHALL output the IV.
REQ-028 Latency: last input byte accepted to ack_valid high SHALL be 66 cycles (64 ROUND + 1 FINAL + 1).

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE with ready_in, data_valid and ack_valid at 0, data_out at 0, H0..H7 at the SHA-256 IV, and the byte/round counters at 0.
REQ-030 Reset mid-LOAD, mid-ROUND or mid-OUT SHALL abandon the operation; no ack is issued.

Structure
REQ-031 A shared package sha_pkg SHALL hold the opcode constants, the state enum, the IV and the K[0..63] table.
REQ-032 One sub-module, sha256_round (combinational: a..h, Kt, Wt in; next a..h out), SHALL be used.
REQ-033 Sigma functions SHALL be package functions.

Verification
REQ-034 HASH_NEW with "abc" padded (61 6263 80, zeros, length 0x18), then READ SHALL give ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-035 HASH_NEW with the empty-message block (80, zeros) SHALL give e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-036 HASH_NEW block1 then HASH_CONT block2 of "abcdbcdecdefdefg...nopq" (448 bits) SHALL give 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-037 READ with data_ready toggled randomly and ack_ready delayed 5 cycles SHALL give no lost or duplicated bytes, and ack_valid SHALL stay high until accepted.
REQ-038 Reset at round 30 then a fresh "abc" HASH_NEW SHALL give the correct digest.
REQ-039 Holding opcode 01 through the ack SHALL not retrigger; module_source_id SHALL be 2'b10 throughout.
